// File: rtl/blink_code_scheduler.sv
// blink_code_scheduler: round-robin shared-LED blink-code sequencer with internal tick prescaler.
// Optional abort input/aborted output when BLINK_SCHED_ABORT_EN is defined.
module blink_code_scheduler #(
   parameter int N         = 499999,
   parameter int CH        = 4,
   parameter int CNT_W     = 4,
   parameter int ON_TICKS  = 40,
   parameter int OFF_TICKS = 40,
   parameter int GAP_TICKS = 120
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef BLINK_SCHED_ABORT_EN
   input  logic                  abort,
`endif
   input  logic [CH-1:0]         req,
   input  logic [CH*CNT_W-1:0]   count,
   output logic [CH-1:0]         ack,
   output logic                  busy,
   output logic [$clog2(CH)-1:0] grant_id,
   output logic                  done,
`ifdef BLINK_SCHED_ABORT_EN
   output logic                  aborted,
`endif
   output logic                  led
);
   localparam int GW = $clog2(CH);
   localparam int PW = (N > 0) ? $clog2(N + 1) : 1;
   localparam int MT = (ON_TICKS > OFF_TICKS) ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                                              : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
   localparam int TW = (MT > 1) ? $clog2(MT) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;
   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [TW-1:0]    ph_q, ph_d, ph_lim;
   logic [CNT_W-1:0] rem_q, rem_d, sel_cnt;
   logic [GW-1:0]    last_q, last_d, gid_q, gid_d, sel;
   logic [CH-1:0]    ack_q, ack_d;
   logic             busy_q, busy_d, done_q, done_d, led_q, led_d;
   logic             found, tick, ph_end;
   int               idx;
`ifdef BLINK_SCHED_ABORT_EN
   logic             aborted_q, aborted_d;
   assign aborted = aborted_q;
`endif
   assign ack      = ack_q;
   assign busy     = busy_q;
   assign grant_id = gid_q;
   assign done     = done_q;
   assign led      = led_q;
   assign tick     = pre_q == PW'(N);
   // Round-robin search starting just above the last granted channel.
   always_comb begin
      found   = 1'b0;
      sel     = '0;
      sel_cnt = '0;
      idx     = 0;
      for (int k = 1; k <= CH; k++) begin
         idx = int'(last_q) + k;
         if (idx >= CH) idx = idx - CH;
         if (!found && req[idx]) begin
            found   = 1'b1;
            sel     = GW'(idx);
            sel_cnt = count[idx*CNT_W +: CNT_W];
         end
      end
   end
   always_comb begin
      state_d = state_q;
      pre_d   = tick ? '0 : pre_q + 1'b1;
      ph_d    = ph_q;
      rem_d   = rem_q;
      last_d  = last_q;
      gid_d   = gid_q;
      ack_d   = '0;
      done_d  = 1'b0;
`ifdef BLINK_SCHED_ABORT_EN
      aborted_d = 1'b0;
`endif
      ph_lim  = state_q == S_ON  ? TW'(ON_TICKS - 1)
              : state_q == S_OFF ? TW'(OFF_TICKS - 1) : TW'(GAP_TICKS - 1);
      ph_end  = tick && ph_q == ph_lim;
      if (state_q == S_IDLE) begin
         if (found) begin
            pre_d      = '0;
            ph_d       = '0;
            rem_d      = sel_cnt;
            last_d     = sel;
            gid_d      = sel;
            ack_d[sel] = 1'b1;
            state_d    = sel_cnt != '0 ? S_ON : S_IDLE;
            done_d     = sel_cnt == '0;
         end
      end
`ifdef BLINK_SCHED_ABORT_EN
      else if (abort) begin
         state_d   = S_IDLE;
         aborted_d = 1'b1;
      end
`endif
      else if (tick) begin
         ph_d = ph_end ? '0 : ph_q + 1'b1;
         if (ph_end) begin
            rem_d   = state_q == S_ON ? rem_q - 1'b1 : rem_q;
            state_d = state_q == S_ON  ? S_OFF
                    : state_q == S_OFF ? (rem_q != '0 ? S_ON : S_GAP) : S_IDLE;
            done_d  = state_q == S_GAP;
         end
      end
      busy_d = state_d != S_IDLE;
      led_d  = state_d == S_ON;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         ph_q    <= '0;
         rem_q   <= '0;
         last_q  <= GW'(CH - 1);
         gid_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         led_q   <= 1'b0;
`ifdef BLINK_SCHED_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         ph_q    <= ph_d;
         rem_q   <= rem_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         led_q   <= led_d;
`ifdef BLINK_SCHED_ABORT_EN
         aborted_q <= aborted_d;
`endif
      end
   end
endmodule

// File: tb/tb_blink_code_scheduler.sv
// tb_blink_code_scheduler: scoreboard bench for blink_code_scheduler with small tick parameters.
module tb_blink_code_scheduler;
   localparam int N = 4, CH = 4, CW = 4, ON = 2, OFF = 2, GAP = 3, P = N + 1;
   logic clk = 1'b0, reset = 1'b1;
   logic [CH-1:0] req = '0;
   logic [CH*CW-1:0] count = '0;
   logic [CH-1:0] ack;
   logic busy, done, led;
   logic [1:0] grant_id;
`ifdef BLINK_SCHED_ABORT_EN
   logic abort = 1'b0;
   logic aborted;
`endif
   int checks = 0, errors = 0;
   typedef struct {int ch; int cnt;} exp_t;
   exp_t sb[$];
   blink_code_scheduler #(.N(N), .CH(CH), .CNT_W(CW), .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)) dut (
      .clk(clk), .reset(reset),
`ifdef BLINK_SCHED_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .req(req), .count(count), .ack(ack), .busy(busy), .grant_id(grant_id), .done(done), .led(led));
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   task automatic set_req(input int ch, input int k);
      req[ch] = 1'b1;
      count[ch*CW +: CW] = CW'(k);
      sb.push_back('{ch, k});
   endtask
   task automatic wait_ack(output int ch, output int k, output int waited);
      exp_t e;
      waited = 0;
      ch = -1;
      k = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (ack !== '0) begin
            waited = i;
            break;
         end
      end
      checks++;
      if (waited == 0) begin
         errors++;
         $display("FAIL ack_timeout: ack=%b after 300 cycles, required a grant", ack);
      end else if (sb.size() == 0) begin
         errors++;
         $display("FAIL ack_unexpected: ack=%b, required no grant", ack);
      end else begin
         e = sb.pop_front();
         ch = e.ch;
         k = e.cnt;
         req[ch] = 1'b0;
         checks++;
         if (ack !== CH'(1 << ch) || grant_id !== 2'(ch)) begin
            errors++;
            $display("FAIL grant_order: ack=%b id=%0d, required channel %0d", ack, grant_id, ch);
         end
      end
   endtask
   task automatic expect_code(input int ch, input int k);
      int len;
      logic e_led, e_busy, e_done;
      logic [CH-1:0] e_ack;
      if (ch < 0) return;
      len = k == 0 ? 0 : k * (ON + OFF) * P + GAP * P;
      for (int o = 1; o <= len + 1; o++) begin
         if (o > 1) @(negedge clk);
         e_led  = o <= k * (ON + OFF) * P && (o - 1) % ((ON + OFF) * P) < ON * P;
         e_busy = o <= len;
         e_done = o == len + 1;
         e_ack  = '0;
         if (o == 1) e_ack[ch] = 1'b1;
         checks++;
         if ({led, busy, done, ack} !== {e_led, e_busy, e_done, e_ack}) begin
            errors++;
            $display("FAIL code_ch%0d_k%0d_t+%0d: led/busy/done/ack=%b/%b/%b/%b, required %b/%b/%b/%b",
                     ch, k, o, led, busy, done, ack, e_led, e_busy, e_done, e_ack);
         end
         if (e_busy) begin
            checks++;
            if (grant_id !== 2'(ch)) begin
               errors++;
               $display("FAIL grant_id_t+%0d: got %0d, required %0d", o, grant_id, ch);
            end
         end
      end
   endtask
   task automatic check_quiet(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         checks++;
         if ({led, busy, done, ack} !== '0) begin
            errors++;
            $display("FAIL %s: led/busy/done/ack=%b/%b/%b/%b, required all 0", name, led, busy, done, ack);
         end
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({led, busy, done, ack, grant_id} !== '0) begin
         errors++;
         $display("FAIL reset_state: led/busy/done/ack/id=%b/%b/%b/%b/%0d, required all 0", led, busy, done, ack, grant_id);
      end
      reset = 1'b0;
      check_quiet("idle_after_reset", 100);
   endtask
   task automatic test_single();
      int ch, k, w;
      set_req(1, 3);
      wait_ack(ch, k, w);
      expect_code(ch, k);
   endtask
   task automatic test_back_to_back();
      int ch, k, w;
      reset = 1'b1;
      set_req(0, 1);
      set_req(2, 1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_ack(ch, k, w);
      expect_code(ch, k);
      wait_ack(ch, k, w);
      checks++;
      if (w != 1) begin
         errors++;
         $display("FAIL b2b_latency: grant after %0d cycles, required 1", w);
      end
      set_req(3, 1);
      set_req(0, 1);
      expect_code(ch, k);
      wait_ack(ch, k, w);
      expect_code(ch, k);
      wait_ack(ch, k, w);
      expect_code(ch, k);
   endtask
   task automatic test_zero_count();
      int ch, k, w;
      set_req(3, 0);
      wait_ack(ch, k, w);
      expect_code(ch, k);
      check_quiet("zero_count_after", 1);
      set_req(1, 1);
      wait_ack(ch, k, w);
      checks++;
      if (w != 1) begin
         errors++;
         $display("FAIL zero_next_latency: grant after %0d cycles, required 1", w);
      end
      expect_code(ch, k);
   endtask
   task automatic test_reset_mid();
      int ch, k, w;
      set_req(1, 3);
      wait_ack(ch, k, w);
      repeat (24) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({led, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid: led/busy/done=%b/%b/%b, required 0/0/0", led, busy, done);
      end
      reset = 1'b0;
      check_quiet("reset_mid_quiet", 20);
      set_req(1, 1);
      set_req(2, 1);
      wait_ack(ch, k, w);
      expect_code(ch, k);
      wait_ack(ch, k, w);
      expect_code(ch, k);
   endtask
   task automatic test_abort();
      int ch, k, w;
      set_req(1, 3);
      wait_ack(ch, k, w);
`ifdef BLINK_SCHED_ABORT_EN
      repeat (14) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({led, busy, done, aborted} !== 4'b0001) begin
         errors++;
         $display("FAIL abort: led/busy/done/aborted=%b/%b/%b/%b, required 0/0/0/1", led, busy, done, aborted);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if ({done, aborted, busy} !== 3'b000) begin
            errors++;
            $display("FAIL abort_after: done/aborted/busy=%b/%b/%b, required 0/0/0", done, aborted, busy);
         end
      end
`else
      expect_code(ch, k);
`endif
   endtask
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_zero_count();
      test_reset_mid();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
